// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder
// Description : Multi-cycle WIDTH-bit adder, DIGIT bits per clock, carry kept
//               in a register between digits; start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int               NDIG     = WIDTH / DIGIT;
  localparam int               CNT_W    = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT:0]     dig_sum;
  logic [WIDTH-1:0]   psum_shift;
  logic               c_into_msb;

  always_comb begin
    dig_sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    // New digit enters at the MSB end so the last digit lands in the top slot.
    psum_shift = (psum_q >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Recover the carry into the top bit from the sum bit and its two addend bits.
    c_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          c_d     = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = dig_sum[DIGIT];
        psum_d = psum_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = psum_shift;
          carry_d = dig_sum[DIGIT];
          ovf_d   = SIGNED ? (c_into_msb ^ dig_sum[DIGIT]) : dig_sum[DIGIT];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_adder
// Description : Directed checks of digit_serial_adder for DIGIT=1/2/8 and SIGNED.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1, in2;
  logic       cin;
  logic       st_m, st_s, st_1, st_8;

  logic       busy_m, done_m, carry_m, ovf_m;
  logic [7:0] sum_m;
  logic       busy_s, done_s, carry_s, ovf_s;
  logic [7:0] sum_s;
  logic       busy_1, done_1, carry_1, ovf_1;
  logic [7:0] sum_1;
  logic       busy_8, done_8, carry_8, ovf_8;
  logic [7:0] sum_8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) u_main (
    .clk(clk), .rst(rst), .start(st_m), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_m), .done(done_m), .sum(sum_m), .carry(carry_m), .overflow(ovf_m));

  digit_serial_adder #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .start(st_s), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_s), .done(done_s), .sum(sum_s), .carry(carry_s), .overflow(ovf_s));

  digit_serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .start(st_1), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_1), .done(done_1), .sum(sum_1), .carry(carry_1), .overflow(ovf_1));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8), .SIGNED(1'b0)) u_d8 (
    .clk(clk), .rst(rst), .start(st_8), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_8), .done(done_8), .sum(sum_8), .carry(carry_8), .overflow(ovf_8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // done must never stay high two cycles in a row on any instance
  logic pd_m = 1'b0, pd_s = 1'b0, pd_1 = 1'b0, pd_8 = 1'b0;
  always @(negedge clk) begin
    if (done_m) check("done_single_m", {31'd0, pd_m}, 32'd0);
    if (done_s) check("done_single_s", {31'd0, pd_s}, 32'd0);
    if (done_1) check("done_single_d1", {31'd0, pd_1}, 32'd0);
    if (done_8) check("done_single_d8", {31'd0, pd_8}, 32'd0);
    pd_m = done_m;
    pd_s = done_s;
    pd_1 = done_1;
    pd_8 = done_8;
  end

  // One operation on all four instances; latency, pulse count, busy length, results.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] full;
    logic       exp_sovf;
    int lat_m, lat_s, lat_1, lat_8;
    int nd_m, nd_s, nd_1, nd_8;
    int nb_m, nb_s, nb_1, nb_8;
    full     = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    exp_sovf = (a[7] == b[7]) && (full[7] != a[7]);
    lat_m = -1; lat_s = -1; lat_1 = -1; lat_8 = -1;
    nd_m = 0; nd_s = 0; nd_1 = 0; nd_8 = 0;
    nb_m = 0; nb_s = 0; nb_1 = 0; nb_8 = 0;
    in1 = a; in2 = b; cin = ci;
    st_m = 1'b1; st_s = 1'b1; st_1 = 1'b1; st_8 = 1'b1;
    @(posedge clk); #1;
    st_m = 1'b0; st_s = 1'b0; st_1 = 1'b0; st_8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (done_m) begin if (lat_m < 0) lat_m = i; nd_m++; end
      if (done_s) begin if (lat_s < 0) lat_s = i; nd_s++; end
      if (done_1) begin if (lat_1 < 0) lat_1 = i; nd_1++; end
      if (done_8) begin if (lat_8 < 0) lat_8 = i; nd_8++; end
      if (busy_m) nb_m++;
      if (busy_s) nb_s++;
      if (busy_1) nb_1++;
      if (busy_8) nb_8++;
    end
    check("lat_m", lat_m, 4);  check("lat_s", lat_s, 4);
    check("lat_d1", lat_1, 8); check("lat_d8", lat_8, 1);
    check("ndone_m", nd_m, 1); check("ndone_s", nd_s, 1);
    check("ndone_d1", nd_1, 1); check("ndone_d8", nd_8, 1);
    check("busy_m", nb_m, 4);  check("busy_s", nb_s, 4);
    check("busy_d1", nb_1, 8); check("busy_d8", nb_8, 1);
    check("sum_m", sum_m, full[7:0]);   check("carry_m", carry_m, full[8]);
    check("ovf_m", ovf_m, full[8]);
    check("sum_s", sum_s, full[7:0]);   check("carry_s", carry_s, full[8]);
    check("ovf_s", ovf_s, exp_sovf);
    check("sum_d1", sum_1, full[7:0]);  check("carry_d1", carry_1, full[8]);
    check("ovf_d1", ovf_1, full[8]);
    check("sum_d8", sum_8, full[7:0]);  check("carry_d8", carry_8, full[8]);
    check("ovf_d8", ovf_8, full[8]);
  endtask

  initial begin
    rst = 1'b1; in1 = 8'd0; in2 = 8'd0; cin = 1'b0;
    st_m = 1'b0; st_s = 1'b0; st_1 = 1'b0; st_8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_m, 0);   check("rst_done", done_m, 0);
    check("rst_sum", sum_m, 0);     check("rst_carry", carry_m, 0);
    check("rst_ovf", ovf_m, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic add, then outputs hold
    run_op(8'h01, 8'h05, 1'b0);
    check("t1_sum", sum_m, 8'h06); check("t1_carry", carry_m, 0); check("t1_ovf", ovf_m, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_hold_sum", sum_m, 8'h06); check("t1_hold_done", done_m, 0);

    // wrap-around and carry-in
    run_op(8'hFF, 8'h01, 1'b0);
    check("t2a_sum", sum_m, 8'h00); check("t2a_carry", carry_m, 1); check("t2a_ovf", ovf_m, 1);
    run_op(8'hFE, 8'h00, 1'b1);
    check("t2b_sum", sum_m, 8'hFF); check("t2b_carry", carry_m, 0);

    // signed overflow
    run_op(8'h7F, 8'h01, 1'b0);
    check("t3a_sum", sum_s, 8'h80); check("t3a_carry", carry_s, 0); check("t3a_ovf", ovf_s, 1);
    run_op(8'h80, 8'hFF, 1'b0);
    check("t3b_sum", sum_s, 8'h7F); check("t3b_carry", carry_s, 1); check("t3b_ovf", ovf_s, 1);
    run_op(8'hFF, 8'h01, 1'b0);
    check("t3c_sum", sum_s, 8'h00); check("t3c_carry", carry_s, 1); check("t3c_ovf", ovf_s, 0);

    // start during RUN ignored; start held through DONE accepted back-to-back
    in1 = 8'h03; in2 = 8'h04; cin = 1'b0; st_m = 1'b1;
    @(posedge clk); #1;
    st_m = 1'b0;
    check("t4_busy0", busy_m, 1); check("t4_done0", done_m, 0);
    @(posedge clk); #1;
    in1 = 8'hAA; in2 = 8'h55; st_m = 1'b1;
    check("t4_done1", done_m, 0);
    @(posedge clk); #1;
    st_m = 1'b0;
    check("t4_busy2", busy_m, 1); check("t4_done2", done_m, 0);
    @(posedge clk); #1;
    check("t4_busy3", busy_m, 1); check("t4_done3", done_m, 0);
    in1 = 8'h11; in2 = 8'h22; st_m = 1'b1;
    @(posedge clk); #1;
    check("t4_done4", done_m, 1); check("t4_busy4", busy_m, 0);
    check("t4_sum", sum_m, 8'h07); check("t4_carry", carry_m, 0);
    @(posedge clk); #1;
    st_m = 1'b0;
    check("t4_b2b_busy", busy_m, 1); check("t4_b2b_done", done_m, 0);
    check("t4_b2b_hold", sum_m, 8'h07);
    repeat (3) @(posedge clk);
    #1;
    check("t4_b2b_done_early", done_m, 0);
    @(posedge clk); #1;
    check("t4_b2b_done", done_m, 1); check("t4_b2b_sum", sum_m, 8'h33);
    @(posedge clk); #1;

    // async reset mid-operation
    in1 = 8'h55; in2 = 8'h66; st_m = 1'b1;
    @(posedge clk); #1;
    st_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_busy", busy_m, 0); check("t5_done", done_m, 0);
    check("t5_sum", sum_m, 0);   check("t5_carry", carry_m, 0); check("t5_ovf", ovf_m, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5_no_done", done_m, 0);
    end
    run_op(8'h10, 8'h20, 1'b0);
    check("t5_sum_fresh", sum_m, 8'h30);

    // sampled sweep across the operand space, including 0x00 and 0xFF corners
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(8'(i * 17), 8'(j * 17), c[0]);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
